// File: rtl/arith_dispatcher.sv
// arith_dispatcher
//   Command-driven sequencer sitting directly in front of the arithmetic
//   pipeline. A command (op + length) is accepted, then FP16 elements are
//   pulled from the output collector and re-issued as a registered,
//   mode-tagged stream. Softmax runs two passes: exp+sum (mode 0) while the
//   scores are buffered locally, then after a fixed drain gap a normalise
//   pass (mode 1) replayed from the buffer.
//
// Parameters
//   K         max softmax vector length (1..16)
//   PASS_GAP  idle cycles between last mode-0 and first mode-1 issue (1..15)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/ready         command handshake; cmd_op, cmd_len command fields
//   dat_valid/ready         element handshake; dat_data, dat_psum element
//   arith_valid/data/psum/mode  registered issue into the pipeline
//   busy                    controller not idle
//   done                    one-cycle completion pulse, trails the last issue

module arith_dispatcher #(
  parameter int K        = 8,
  parameter int PASS_GAP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_len,
  input  logic        dat_valid,
  output logic        dat_ready,
  input  logic [15:0] dat_data,
  input  logic [15:0] dat_psum,
  output logic        arith_valid,
  output logic [15:0] arith_data,
  output logic [15:0] arith_psum,
  output logic [1:0]  arith_mode,
  output logic        busy,
  output logic        done
);

  localparam int         IDX_W    = (K > 1) ? $clog2(K) : 1;
  localparam logic [7:0] K_LEN    = 8'(K);
  localparam logic [3:0] GAP_INIT = 4'(PASS_GAP);

  localparam logic [1:0] OP_SOFTMAX = 2'd0;
  localparam logic [1:0] OP_ILLEGAL = 2'd1;
  localparam logic [1:0] OP_AGG     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SM_EXP,
    S_SM_GAP,
    S_SM_NORM,
    S_STREAM,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [3:0]         gap_q, gap_d;
  logic               arith_valid_q, arith_valid_d;
  logic [15:0]        arith_data_q, arith_data_d;
  logic [15:0]        arith_psum_q, arith_psum_d;
  logic [1:0]         arith_mode_q, arith_mode_d;
  logic               done_q, done_d;

  logic [15:0]        score_q [K];

  logic               cmd_fire;
  logic               dat_fire;
  logic               score_we;
  logic [7:0]         eff_len;
  logic               last_beat;

  // done is registered one cycle behind the DONE state so the pulse lands
  // the cycle after the final issue; masking cmd_ready with it keeps the
  // next command from being taken until the cycle after the pulse.
  assign cmd_ready   = (state_q == S_IDLE) && !done_q;
  assign dat_ready   = ((state_q == S_SM_EXP) || (state_q == S_STREAM)) &&
                       (beat_cnt_q < len_q);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign arith_valid = arith_valid_q;
  assign arith_data  = arith_data_q;
  assign arith_psum  = arith_psum_q;
  assign arith_mode  = arith_mode_q;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign dat_fire  = dat_valid && dat_ready;
  assign score_we  = (state_q == S_SM_EXP) && dat_fire;
  assign last_beat = (beat_cnt_q == (len_q - 8'd1));

  // Softmax is capped at K elements; surplus stays upstream.
  always_comb begin
    eff_len = cmd_len;
    if ((cmd_op == OP_SOFTMAX) && (cmd_len > K_LEN)) begin
      eff_len = K_LEN;
    end
  end

  // Next-state and output computation. The issue registers only change on
  // an actual issue, so mode/data/psum hold steady through gaps and idle.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    gap_d         = gap_q;
    arith_valid_d = 1'b0;
    arith_data_d  = arith_data_q;
    arith_psum_d  = arith_psum_q;
    arith_mode_d  = arith_mode_q;
    done_d        = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          op_d       = cmd_op;
          len_d      = eff_len;
          beat_cnt_d = 8'd0;
          wr_idx_d   = '0;
          rd_idx_d   = '0;
          if ((eff_len == 8'd0) || (cmd_op == OP_ILLEGAL)) begin
            state_d = S_DONE;
          end else if (cmd_op == OP_SOFTMAX) begin
            state_d = S_SM_EXP;
          end else begin
            state_d = S_STREAM;
          end
        end
      end

      S_SM_EXP: begin
        if (dat_fire) begin
          wr_idx_d      = wr_idx_q + IDX_W'(1);
          beat_cnt_d    = beat_cnt_q + 8'd1;
          arith_valid_d = 1'b1;
          arith_mode_d  = 2'd0;
          arith_data_d  = dat_data;
          arith_psum_d  = 16'd0;
          if (last_beat) begin
            state_d    = S_SM_GAP;
            gap_d      = GAP_INIT;
            beat_cnt_d = 8'd0;
          end
        end
      end

      // Leaving when the timer is at 1 makes exactly PASS_GAP issue-free
      // cycles, because the first mode-1 issue is registered one cycle
      // after SM_NORM is entered.
      S_SM_GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d    = 4'd0;
          rd_idx_d = '0;
          state_d  = S_SM_NORM;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      S_SM_NORM: begin
        arith_valid_d = 1'b1;
        arith_mode_d  = 2'd1;
        arith_data_d  = score_q[rd_idx_q];
        arith_psum_d  = 16'd0;
        rd_idx_d      = rd_idx_q + IDX_W'(1);
        beat_cnt_d    = beat_cnt_q + 8'd1;
        if (last_beat) begin
          state_d = S_DONE;
        end
      end

      S_STREAM: begin
        if (dat_fire) begin
          beat_cnt_d    = beat_cnt_q + 8'd1;
          arith_valid_d = 1'b1;
          arith_mode_d  = op_q;
          arith_data_d  = dat_data;
          arith_psum_d  = (op_q == OP_AGG) ? dat_psum : 16'd0;
          if (last_beat) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state and registered pipeline outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= 2'd0;
      len_q         <= 8'd0;
      beat_cnt_q    <= 8'd0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      gap_q         <= 4'd0;
      arith_valid_q <= 1'b0;
      arith_data_q  <= 16'd0;
      arith_psum_q  <= 16'd0;
      arith_mode_q  <= 2'd0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      len_q         <= len_d;
      beat_cnt_q    <= beat_cnt_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      gap_q         <= gap_d;
      arith_valid_q <= arith_valid_d;
      arith_data_q  <= arith_data_d;
      arith_psum_q  <= arith_psum_d;
      arith_mode_q  <= arith_mode_d;
      done_q        <= done_d;
    end
  end

  // Score buffer has no reset: it is always written before being replayed.
  always_ff @(posedge clk) begin
    if (score_we) begin
      score_q[wr_idx_q] <= dat_data;
    end
  end

endmodule

// File: tb/tb_arith_dispatcher.sv
// tb_arith_dispatcher
//   Directed bench for arith_dispatcher. Stimulus pushes the expected issue
//   stream into a scoreboard queue; an independent monitor pops and compares
//   on every arith_valid, checks that mode/data/psum hold between issues, and
//   logs issue/done cycles for the timing checks done by the stimulus.

module tb_arith_dispatcher;

  localparam int K        = 8;
  localparam int PASS_GAP = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_len;
  logic        dat_valid;
  logic        dat_ready;
  logic [15:0] dat_data;
  logic [15:0] dat_psum;
  logic        arith_valid;
  logic [15:0] arith_data;
  logic [15:0] arith_psum;
  logic [1:0]  arith_mode;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] psum;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q [$];
  int          log_cyc [$];
  exp_t        hold_val;
  logic [15:0] vec_data [16];
  logic [15:0] vec_psum [16];

  int tests           = 0;
  int fails           = 0;
  int cyc             = 0;
  int done_cnt        = 0;
  int done_cyc        = 0;
  int acc_cnt         = 0;
  int accept_edge     = 0;
  int first_beat_edge = 0;

  arith_dispatcher #(
    .K        (K),
    .PASS_GAP (PASS_GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .dat_valid   (dat_valid),
    .dat_ready   (dat_ready),
    .dat_data    (dat_data),
    .dat_psum    (dat_psum),
    .arith_valid (arith_valid),
    .arith_data  (arith_data),
    .arith_psum  (arith_psum),
    .arith_mode  (arith_mode),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: after posedge n (and at the following negedge) cyc == n.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare on issue, hold check otherwise.
  initial begin
    exp_t e;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_val = '0;
      end else begin
        if (dat_valid && dat_ready) acc_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (arith_valid) begin
          log_cyc.push_back(cyc);
          checkOutput("sb_nonempty", 64'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("issue", {arith_mode, arith_psum, arith_data}, e);
            hold_val = e;
          end
        end else begin
          checkOutput("hold", {arith_mode, arith_psum, arith_data}, hold_val);
        end
      end
    end
  end

  task automatic sendCmd(input logic [1:0] op, input logic [7:0] len);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("cmd_accept", 64'(ok), 1);
    if (ok) begin
      @(posedge clk);
      #1;
      accept_edge = cyc;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic sendBeat(input logic [15:0] d, input logic [15:0] p,
                          output int edge_no);
    bit ok;
    ok        = 1'b0;
    edge_no   = 0;
    dat_valid = 1'b1;
    dat_data  = d;
    dat_psum  = p;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dat_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("beat_accept", 64'(ok), 1);
    if (ok) begin
      @(posedge clk);
      #1;
      edge_no = cyc;
    end
    dat_valid = 1'b0;
  endtask

  // Issue a command, feed n_beats elements (with gap idle cycles between
  // beats) and push the expected pipeline stream.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] len,
                               input int n_beats, input int gap);
    int e;
    log_cyc.delete();
    acc_cnt = 0;
    sendCmd(op, len);
    for (int b = 0; b < n_beats; b++) begin
      sendBeat(vec_data[b], vec_psum[b], e);
      if (b == 0) first_beat_edge = e;
      exp_q.push_back({op, (op == 2'd3) ? vec_psum[b] : 16'h0000, vec_data[b]});
      if (b != n_beats - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk);
          #1;
        end
      end
    end
    if (op == 2'd0) begin
      for (int b = 0; b < n_beats; b++) begin
        exp_q.push_back({2'd1, 16'h0000, vec_data[b]});
      end
    end
  endtask

  task automatic waitDone(input int bound);
    int start;
    bit ok;
    start = done_cnt;
    ok    = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > start) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", 64'(ok), 1);
  endtask

  task automatic checkDoneAfterLast(input string name);
    if (log_cyc.size() > 0) begin
      checkOutput(name, done_cyc, log_cyc[$] + 1);
    end
  endtask

  initial begin
    bit ok;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_len   = 8'd0;
    dat_valid = 1'b0;
    dat_data  = 16'h0000;
    dat_psum  = 16'h0000;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;

    // Reset values
    @(negedge clk);
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_dat_ready", dat_ready, 0);
    checkOutput("rst_arith_valid", arith_valid, 0);
    checkOutput("rst_arith_data", arith_data, 0);
    checkOutput("rst_arith_psum", arith_psum, 0);
    checkOutput("rst_arith_mode", arith_mode, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Softmax, length 4, continuous input
    vec_data[0] = 16'h3C00; vec_data[1] = 16'h4000;
    vec_data[2] = 16'h4200; vec_data[3] = 16'h4400;
    for (int i = 0; i < 4; i++) vec_psum[i] = 16'h0000;
    applyStimulus(2'd0, 8'd4, 4, 0);
    checkOutput("sm4_busy", busy, 1);
    waitDone(60);
    checkOutput("sm4_issue_count", log_cyc.size(), 8);
    if (log_cyc.size() == 8) begin
      checkOutput("sm4_latency", log_cyc[0], first_beat_edge);
      checkOutput("sm4_exp_b2b", log_cyc[3] - log_cyc[0], 3);
      checkOutput("sm4_gap", log_cyc[4] - log_cyc[3] - 1, PASS_GAP);
      checkOutput("sm4_norm_b2b", log_cyc[7] - log_cyc[4], 3);
    end
    checkDoneAfterLast("sm4_done_timing");

    // GeLU, length 3, valid pattern 1,0,1,0,1; psum must be dropped
    vec_data[0] = 16'h4000; vec_data[1] = 16'h4200; vec_data[2] = 16'h4400;
    for (int i = 0; i < 3; i++) vec_psum[i] = 16'h1234;
    applyStimulus(2'd2, 8'd3, 3, 1);
    waitDone(40);
    checkOutput("gelu_issue_count", log_cyc.size(), 3);
    if (log_cyc.size() == 3) begin
      checkOutput("gelu_space01", log_cyc[1] - log_cyc[0], 2);
      checkOutput("gelu_space12", log_cyc[2] - log_cyc[1], 2);
    end
    checkDoneAfterLast("gelu_done_timing");

    // AGG, length 2, psum carried
    vec_data[0] = 16'h3800; vec_psum[0] = 16'h3C00;
    vec_data[1] = 16'h4000; vec_psum[1] = 16'h4400;
    applyStimulus(2'd3, 8'd2, 2, 0);
    waitDone(40);
    checkOutput("agg_issue_count", log_cyc.size(), 2);
    checkDoneAfterLast("agg_done_timing");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("agg_mode_hold", arith_mode, 3);

    // Softmax, length 10 > K: only K beats consumed
    for (int i = 0; i < 8; i++) begin
      vec_data[i] = 16'h3000 + 16'(i * 16'h0100);
      vec_psum[i] = 16'h0000;
    end
    applyStimulus(2'd0, 8'd10, 8, 0);
    dat_valid = 1'b1;
    dat_data  = 16'h5555;
    dat_psum  = 16'h0000;
    @(negedge clk);
    checkOutput("sm10_ready_low", dat_ready, 0);
    waitDone(80);
    dat_valid = 1'b0;
    checkOutput("sm10_beats", acc_cnt, 8);
    checkOutput("sm10_issue_count", log_cyc.size(), 16);
    if (log_cyc.size() == 16) begin
      checkOutput("sm10_gap", log_cyc[8] - log_cyc[7] - 1, PASS_GAP);
    end
    checkDoneAfterLast("sm10_done_timing");

    // Zero-length and illegal commands: done only, nothing consumed
    for (int t = 0; t < 4; t++) begin
      logic [1:0] zop;
      logic [7:0] zlen;
      case (t)
        0:       begin zop = 2'd2; zlen = 8'd0; end
        1:       begin zop = 2'd1; zlen = 8'd5; end
        2:       begin zop = 2'd0; zlen = 8'd0; end
        default: begin zop = 2'd3; zlen = 8'd0; end
      endcase
      dat_valid = 1'b1;
      dat_data  = 16'h7777;
      applyStimulus(zop, zlen, 0, 0);
      waitDone(10);
      checkOutput("zl_done_timing", done_cyc, accept_edge + 1);
      checkOutput("zl_ready_in_done", cmd_ready, 0);
      @(negedge clk);
      #1;
      checkOutput("zl_ready_after", cmd_ready, 1);
      checkOutput("zl_no_issue", log_cyc.size(), 0);
      checkOutput("zl_no_beats", acc_cnt, 0);
      dat_valid = 1'b0;
    end

    // Reset in the middle of the normalise pass
    vec_data[0] = 16'h4600; vec_data[1] = 16'h4700;
    vec_data[2] = 16'h4800; vec_data[3] = 16'h4900;
    for (int i = 0; i < 4; i++) vec_psum[i] = 16'h0000;
    applyStimulus(2'd0, 8'd4, 4, 0);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (log_cyc.size() >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("rst_reach_norm", 64'(ok), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", arith_valid, 0);
    checkOutput("midrst_mode", arith_mode, 0);
    checkOutput("midrst_data", arith_data, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_cmd_ready", cmd_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("midrst_no_issue", arith_valid, 0);
    rst_n = 1'b1;

    vec_data[0] = 16'h4A00; vec_data[1] = 16'h4C00;
    applyStimulus(2'd0, 8'd2, 2, 0);
    waitDone(40);
    checkOutput("postrst_issue_count", log_cyc.size(), 4);
    checkDoneAfterLast("postrst_done_timing");

    repeat (2) @(negedge clk);
    checkOutput("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
